// File: rtl/f2f_lvds_tx_framer_if.sv
// Word stream into the BLVDS transmit framer: valid/ready with an end-of-frame marker.
interface f2f_lvds_tx_framer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] S_DATA_I;
    logic              S_VALID_I;
    logic              S_LAST_I;
    logic              S_READY_O;

    modport master (output S_DATA_I, S_VALID_I, S_LAST_I, input  S_READY_O);
    modport slave  (input  S_DATA_I, S_VALID_I, S_LAST_I, output S_READY_O);
endinterface

// File: rtl/f2f_lvds_tx_framer.sv
// BLVDS transmit framer: serialises stream words into 5-bit lane symbols and owns
// driver turnaround on the shared lanes (drives only while a frame is in flight).
//
// state    | meaning
// IDLE     | lanes released, waiting for EN_I and a valid word
// TURN_ON  | driver enabled, IDLE guard symbols
// SOF      | start-of-frame symbol, first word offered
// DATA     | payload nibbles, MSB first
// STALL    | upstream starved mid-frame, IDLE filler
// CHK      | XOR checksum of all payload nibbles
// EOF      | end-of-frame symbol
// TURN_OFF | IDLE guard symbols before release
module f2f_lvds_tx_framer #(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 16,
    parameter int TURN_CYC  = 2
) (
    input  logic                CLK_I,
    input  logic                RSTN_I,
    input  logic                EN_I,
    f2f_lvds_tx_framer_if.slave s_if,
    output logic [4:0]          TX_DAT_O,
    output logic                TX_T_O,
    output logic                BUSY_O,
    output logic [15:0]         FRM_CNT_O,
    output logic                TRUNC_O
);
    localparam int NW  = DATA_W / 4;
    localparam int NBW = (NW > 1) ? $clog2(NW) : 1;
    localparam int WCW = $clog2(MAX_WORDS + 1);
    localparam int TW  = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [4:0] SYM_IDLE = 5'b1_0000;
    localparam logic [4:0] SYM_SOF  = 5'b1_1010;
    localparam logic [4:0] SYM_EOF  = 5'b1_0101;

    typedef enum logic [2:0] {
        ST_IDLE, ST_TURN_ON, ST_SOF, ST_DATA, ST_STALL, ST_CHK, ST_EOF, ST_TURN_OFF
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [NBW-1:0]    r_nib, w_nib_nxt;
    logic [WCW-1:0]    r_wcnt, w_wcnt_nxt;
    logic              r_last, w_last_nxt;
    logic [3:0]        r_chk, w_chk_nxt, w_nib_val;
    logic [TW-1:0]     r_tmr, w_tmr_nxt;
    logic              r_ready, w_ready_nxt;
    logic [4:0]        r_dat, w_dat_nxt;
    logic              r_t, r_busy, r_trunc, w_trunc_nxt;
    logic [15:0]       r_frm, w_frm_nxt;
    logic              w_xfer, w_close, w_load;

    assign w_xfer  = r_ready & s_if.S_VALID_I;
    assign w_close = r_last | (r_wcnt == WCW'(MAX_WORDS));

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_nib_nxt   = r_nib;
        w_wcnt_nxt  = r_wcnt;
        w_last_nxt  = r_last;
        w_chk_nxt   = r_chk;
        w_tmr_nxt   = r_tmr;
        w_trunc_nxt = 1'b0;
        w_frm_nxt   = r_frm;
        w_load      = 1'b0;
        w_nib_val   = 4'h0;
        w_dat_nxt   = SYM_IDLE;
        w_ready_nxt = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (EN_I && s_if.S_VALID_I) begin
                    w_state_nxt = ST_TURN_ON;
                    w_tmr_nxt   = TW'(TURN_CYC - 1);
                end
            end
            ST_TURN_ON: begin
                if (r_tmr == '0) begin
                    w_state_nxt = ST_SOF;
                    w_chk_nxt   = 4'h0;
                    w_wcnt_nxt  = '0;
                end else begin
                    w_tmr_nxt = r_tmr - TW'(1);
                end
            end
            ST_SOF: begin
                if (w_xfer) w_load = 1'b1;
                else        w_state_nxt = ST_STALL;
            end
            ST_DATA: begin
                if (r_nib != NBW'(NW - 1)) begin
                    w_nib_val   = r_shift[DATA_W-1 -: 4];
                    w_shift_nxt = r_shift << 4;
                    w_nib_nxt   = r_nib + NBW'(1);
                end else if (w_close) begin
                    w_state_nxt = ST_CHK;
                    w_trunc_nxt = ~r_last;
                end else if (w_xfer) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nxt = ST_STALL;
                end
            end
            ST_STALL: begin
                if (w_xfer) w_load = 1'b1;
            end
            ST_CHK:  w_state_nxt = ST_EOF;
            ST_EOF: begin
                w_state_nxt = ST_TURN_OFF;
                w_tmr_nxt   = TW'(TURN_CYC - 1);
                w_frm_nxt   = r_frm + 16'd1;
            end
            ST_TURN_OFF: begin
                if (r_tmr == '0) w_state_nxt = ST_IDLE;
                else             w_tmr_nxt   = r_tmr - TW'(1);
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A fresh word goes straight onto the lane, so back-to-back words have no bubble
        if (w_load) begin
            w_state_nxt = ST_DATA;
            w_nib_val   = s_if.S_DATA_I[DATA_W-1 -: 4];
            w_shift_nxt = s_if.S_DATA_I << 4;
            w_nib_nxt   = '0;
            w_wcnt_nxt  = r_wcnt + WCW'(1);
            w_last_nxt  = s_if.S_LAST_I;
        end

        if (w_state_nxt == ST_DATA) w_chk_nxt = r_chk ^ w_nib_val;

        // Ready is offered during the last nibble so the next word lands without a gap
        w_ready_nxt = (w_state_nxt == ST_SOF) || (w_state_nxt == ST_STALL) ||
                      ((w_state_nxt == ST_DATA) && (w_nib_nxt == NBW'(NW - 1)) &&
                       !w_last_nxt && (w_wcnt_nxt != WCW'(MAX_WORDS)));

        unique case (w_state_nxt)
            ST_IDLE: w_dat_nxt = 5'b0_0000;
            ST_SOF:  w_dat_nxt = SYM_SOF;
            ST_DATA: w_dat_nxt = {1'b0, w_nib_val};
            ST_CHK:  w_dat_nxt = {1'b0, r_chk};
            ST_EOF:  w_dat_nxt = SYM_EOF;
            default: w_dat_nxt = SYM_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_nib   <= '0;
            r_wcnt  <= '0;
            r_last  <= 1'b0;
            r_chk   <= 4'h0;
            r_tmr   <= '0;
            r_ready <= 1'b0;
            r_dat   <= 5'b0_0000;
            r_t     <= 1'b1;
            r_busy  <= 1'b0;
            r_trunc <= 1'b0;
            r_frm   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_nib   <= w_nib_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_last  <= w_last_nxt;
            r_chk   <= w_chk_nxt;
            r_tmr   <= w_tmr_nxt;
            r_ready <= w_ready_nxt;
            r_dat   <= w_dat_nxt;
            r_t     <= (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_trunc <= w_trunc_nxt;
            r_frm   <= w_frm_nxt;
        end
    end

    assign s_if.S_READY_O = r_ready;
    assign TX_DAT_O       = r_dat;
    assign TX_T_O         = r_t;
    assign BUSY_O         = r_busy;
    assign FRM_CNT_O      = r_frm;
    assign TRUNC_O        = r_trunc;
endmodule

// File: doc/f2f_lvds_tx_framer.md
Name: f2f_lvds_tx_framer

Overview:
Transmit-side framer for the FPGA-to-FPGA BLVDS link. It accepts 32-bit words on a valid/ready stream and emits one 5-bit lane symbol per clock. The lane symbols feed the pad wrapper's data-drive inputs, and the tri-state enable feeds its DAT_T. The block owns bus turnaround: it drives the shared differential lanes only while a frame is in flight and releases them (T=1) when idle.

Parameters:
DATA_W, 32, payload word width; must be a multiple of 4; nibbles per word NW = DATA_W/4
MAX_WORDS, 16, maximum words per frame; the frame is force-closed after this many words
TURN_CYC, 2, guard cycles of driven IDLE symbols after the driver enables and before it releases; must be at least 1

Ports:
CLK_I  in  1  link clock; the same clock is forwarded to the far end
RSTN_I  in  1  asynchronous active-low reset
EN_I  in  1  link enable; sampled only in IDLE
S_DATA_I  in  DATA_W  payload word
S_VALID_I  in  1  word valid
S_LAST_I  in  1  marks the final word of a frame
S_READY_O  out  1  word accepted on a cycle where S_VALID_I and S_READY_O are both high
TX_DAT_O  out  5  lane symbol to the pad wrapper's drive inputs
TX_T_O  out  1  tri-state control to DAT_T; 1 = release lanes, 0 = drive
BUSY_O  out  1  high in every state except IDLE
FRM_CNT_O  out  16  count of completed frames; wraps at 0xFFFF -> 0
TRUNC_O  out  1  one-cycle pulse when a frame is closed at MAX_WORDS without S_LAST_I

Behaviour:
- Symbol encoding: bit4 = control flag.
  - Control symbols: IDLE = 5'b1_0000, SOF = 5'b1_1010, EOF = 5'b1_0101.
  - Data symbols: bit4 = 0, bits[3:0] = payload nibble, sent MSB nibble first.
- All outputs are registered.
- Reset values: TX_T_O=1, TX_DAT_O=0, S_READY_O=0, BUSY_O=0, FRM_CNT_O=0, TRUNC_O=0, state=IDLE.
- RSTN_I asserted mid-frame: all outputs return to their reset values immediately. No EOF is sent; the receiver discards the partial frame.
- FSM states: IDLE, TURN_ON, SOF, DATA, STALL, CHK, EOF, TURN_OFF.
- IDLE:
  - Outputs: TX_T_O=1, TX_DAT_O=0.
  - When EN_I=1 and S_VALID_I=1, go to TURN_ON.
- TURN_ON:
  - TX_T_O=0, emits IDLE for TURN_CYC cycles, then goes to SOF.
- SOF:
  - Emits SOF for one cycle with S_READY_O=1.
  - If the word transfers: load the shift register, set word_cnt=1, go to DATA.
  - If no transfer: go to STALL. Upstream may drop valid.
- DATA:
  - Emits one data nibble per cycle.
  - Checksum accumulator ^= each emitted nibble.
  - On the last nibble (nib_cnt = NW-1) with the frame not closing, S_READY_O=1:
    - Transfer: load the next word so nibbles continue back-to-back with no bubble; word_cnt++.
    - No transfer: go to STALL.
  - Frame closes after the last nibble of a word accepted with S_LAST_I=1, or of word number MAX_WORDS; then go to CHK.
  - On the MAX_WORDS close without last, TRUNC_O pulses in the CHK cycle.
  - The next word then starts a new frame.
- STALL:
  - Emits IDLE with S_READY_O=1 until a transfer occurs, then goes to DATA.
  - Stall symbols do not affect the checksum.
- CHK:
  - Emits 5'b0_cccc, where cccc = XOR of all payload nibbles in the frame.
- EOF:
  - Emits EOF for one cycle.
  - FRM_CNT_O increments on the cycle after EOF.
- TURN_OFF:
  - Emits IDLE with TX_T_O=0 for TURN_CYC cycles.
  - Then TX_T_O=1 and the FSM returns to IDLE; IDLE lasts at least one cycle before the next TURN_ON.
- EN_I deasserted mid-frame: ignored; the frame completes normally. A new frame is not started until EN_I=1.
- S_READY_O is 0 in IDLE, TURN_ON, CHK, EOF and TURN_OFF.
- Latency: S_VALID_I rises in IDLE at cycle 0.
  - TX_T_O falls at cycle 1.
  - SOF appears at cycle TURN_CYC+1.
  - First nibble appears at cycle TURN_CYC+2 if the word transfers during SOF.
- Minimum frame length on the lane, excluding turnaround: 1 + NW*words + 2 symbols.

Test Plan:
- Defaults, single word 0x12345678 with last, valid held high. Required lane sequence: T falls; IDLE, IDLE; SOF; nibbles 1,2,3,4,5,6,7,8; CHK 5'h08; EOF; IDLE, IDLE; then T=1. FRM_CNT_O=1, TRUNC_O never pulses.
- Two words 0xAAAAAAAA, 0x55555555 (last), valid continuous. Required: 16 data symbols with no gap; S_READY_O high exactly in the SOF cycle and the cycle of nibble 7 of word 1; CHK=5'h00.
- Valid drops for 3 cycles after word 1 of a 2-word frame. Required: 3 IDLE stall symbols between word 1's last nibble and word 2's first; checksum unchanged vs the no-stall case.
- Default MAX_WORDS=16, 17 consecutive words, last only on word 17. Required: frame 1 carries 16 words and TRUNC_O pulses once; frame 2 carries 1 word after a full TURN_OFF/IDLE/TURN_ON; FRM_CNT_O=2.
- EN_I=0 with S_VALID_I=1. Required: no frame; T stays 1 and S_READY_O stays 0. Then deassert EN_I during DATA: the frame still completes with EOF.
- RSTN_I pulsed low during DATA. Required: same cycle, TX_T_O=1, TX_DAT_O=0, S_READY_O=0, FRM_CNT_O=0. After release, a new frame starts cleanly with SOF.
